lo_manchester_tx: RTL and testbench

- LF tag-emulation transmitter: the outbound counterpart of the LF edge-detect receive path.
- Accepts bytes from the ARM over a valid/ready byte interface and Manchester-encodes them, MSB first.
- Modulates the tag load (pwr_oe2..4) in lock-step with an internally divided carrier clock that also drives adc_clk.
- Sits in the LF major-mode mux beside the edge-detect receiver and shares its divisor register.

---
 rtl/lo_manchester_tx.sv | 156 +++++++++++++++
 tb/tb_lo_manchester_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lo_manchester_tx.sv
// LF tag-emulation transmitter: Manchester-encodes bytes MSB first and
// modulates the tag load in lock-step with an internally divided carrier.
module lo_manchester_tx #(
  parameter logic INVERT = 1'b0,
  parameter int   HB_W   = 6
) (
  input  logic            pck0,
  input  logic            reset,
  input  logic [7:0]      divisor,
  input  logic [HB_W-1:0] half_bit,
  input  logic            lf_field,
  input  logic [7:0]      data_in,
  input  logic            data_valid,
  output logic            data_ready,
  output logic            busy,
  output logic            tx_done,
  output logic            adc_clk,
  output logic            pwr_oe1,
  output logic            pwr_oe2,
  output logic            pwr_oe3,
  output logic            pwr_oe4,
  output logic            pwr_hi,
  output logic            pwr_lo,
  output logic            dbg
);

  // Byte handshake: a byte moves when data_valid && data_ready at a rising
  // pck0 edge; data_ready is registered and equals "holding register empty".

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_carrier;
  logic [7:0]      r_hold;
  logic            r_hold_full;
  logic            r_data_ready;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic [HB_W-1:0] r_hb_cnt;
  logic            r_mod;
  logic            r_busy;
  logic            r_tx_done;

  logic            w_tick;
  logic [HB_W-1:0] w_hb_last;
  logic            w_hb_end;
  logic            w_accept;

  function automatic logic enc(input logic b, input logic first);
    return first ? (b ^ INVERT) : ~(b ^ INVERT);
  endfunction

  // >= rather than == so a divisor lowered mid-count still wraps promptly.
  assign w_tick    = (r_cnt >= divisor) && !r_carrier;
  assign w_hb_last = (half_bit == '0) ? '0 : half_bit - HB_W'(1);
  assign w_hb_end  = w_tick && (r_hb_cnt >= w_hb_last);
  assign w_accept  = data_valid && r_data_ready;

  always_ff @(posedge pck0) begin
    if (reset) begin
      r_cnt     <= '0;
      r_carrier <= 1'b0;
    end else if (r_cnt >= divisor) begin
      r_cnt     <= '0;
      r_carrier <= ~r_carrier;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge pck0) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_data_ready <= 1'b1;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_hb_cnt     <= '0;
      r_mod        <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      // Accept and reload never coincide: reload needs a full holding register.
      if (w_accept) begin
        r_hold       <= data_in;
        r_hold_full  <= 1'b1;
        r_data_ready <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_tick && r_hold_full) begin
            r_shift      <= r_hold;
            r_hold_full  <= 1'b0;
            r_data_ready <= 1'b1;
            r_bit_idx    <= 3'd7;
            r_hb_cnt     <= '0;
            r_busy       <= 1'b1;
            r_mod        <= enc(r_hold[7], 1'b1);
            r_state      <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (w_hb_end) begin
            r_hb_cnt <= '0;
            r_mod    <= enc(r_shift[7], 1'b0);
            r_state  <= S_SECOND;
          end else if (w_tick) begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
          end
        end
        S_SECOND: begin
          if (w_hb_end) begin
            r_hb_cnt <= '0;
            if (r_bit_idx != 3'd0) begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_bit_idx <= r_bit_idx - 3'd1;
              r_mod     <= enc(r_shift[6], 1'b1);
              r_state   <= S_FIRST;
            end else if (r_hold_full) begin
              r_shift      <= r_hold;
              r_hold_full  <= 1'b0;
              r_data_ready <= 1'b1;
              r_bit_idx    <= 3'd7;
              r_mod        <= enc(r_hold[7], 1'b1);
              r_state      <= S_FIRST;
            end else begin
              r_mod     <= 1'b0;
              r_busy    <= 1'b0;
              r_tx_done <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_tick) begin
            r_hb_cnt <= r_hb_cnt + HB_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_ready = r_data_ready;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;
  assign adc_clk    = ~r_carrier;
  assign pwr_oe1    = 1'b0;
  assign pwr_hi     = 1'b0;
  assign pwr_lo     = 1'b0;
  assign pwr_oe2    = r_mod & ~lf_field;
  assign pwr_oe3    = r_mod & ~lf_field;
  assign pwr_oe4    = r_mod & ~lf_field;
  assign dbg        = r_mod;

endmodule

// File: tb/tb_lo_manchester_tx.sv
// Directed bench for lo_manchester_tx: expected half-bit levels are queued
// when bytes are written and compared mid-half-bit as the encoder plays them.
module tb_lo_manchester_tx;

  logic       pck0 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] div = 8'd1;
  logic [5:0] hb = 6'd2;
  logic       lf_field = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       sel = 1'b0;

  logic [1:0] ready_w, busy_w, done_w, adc_w, oe1_w, oe2_w, oe3_w, oe4_w, hi_w, lo_w, dbg_w;

  logic [0:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  always #5 pck0 = ~pck0;

  lo_manchester_tx #(.INVERT(1'b0), .HB_W(6)) dut0 (
    .pck0(pck0), .reset(reset), .divisor(div), .half_bit(hb), .lf_field(lf_field),
    .data_in(data_in), .data_valid(data_valid), .data_ready(ready_w[0]),
    .busy(busy_w[0]), .tx_done(done_w[0]), .adc_clk(adc_w[0]),
    .pwr_oe1(oe1_w[0]), .pwr_oe2(oe2_w[0]), .pwr_oe3(oe3_w[0]), .pwr_oe4(oe4_w[0]),
    .pwr_hi(hi_w[0]), .pwr_lo(lo_w[0]), .dbg(dbg_w[0]));

  lo_manchester_tx #(.INVERT(1'b1), .HB_W(6)) dut1 (
    .pck0(pck0), .reset(reset), .divisor(div), .half_bit(hb), .lf_field(lf_field),
    .data_in(data_in), .data_valid(data_valid), .data_ready(ready_w[1]),
    .busy(busy_w[1]), .tx_done(done_w[1]), .adc_clk(adc_w[1]),
    .pwr_oe1(oe1_w[1]), .pwr_oe2(oe2_w[1]), .pwr_oe3(oe3_w[1]), .pwr_oe4(oe4_w[1]),
    .pwr_hi(hi_w[1]), .pwr_lo(lo_w[1]), .dbg(dbg_w[1]));

  logic m_ready, m_busy, m_done, m_adc, m_oe1, m_oe2, m_oe3, m_oe4, m_hi, m_lo, m_dbg;
  assign m_ready = ready_w[sel];
  assign m_busy  = busy_w[sel];
  assign m_done  = done_w[sel];
  assign m_adc   = adc_w[sel];
  assign m_oe1   = oe1_w[sel];
  assign m_oe2   = oe2_w[sel];
  assign m_oe3   = oe3_w[sel];
  assign m_oe4   = oe4_w[sel];
  assign m_hi    = hi_w[sel];
  assign m_lo    = lo_w[sel];
  assign m_dbg   = dbg_w[sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference Manchester encoding: bit 1 is high-then-low unless inverted.
  task automatic enc_push(input logic [7:0] b, input logic inv);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(b[i] ^ inv);
      exp_q.push_back(~(b[i] ^ inv));
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int w;
    enc_push(b, sel);
    w = 0;
    while (!m_ready && w < 1000) begin @(negedge pck0); w++; end
    check("push_ready", m_ready, 1'b1);
    data_in    = b;
    data_valid = 1'b1;
    @(negedge pck0);
    data_valid = 1'b0;
  endtask

  // Follows one transmission from its first edge; optionally writes a second
  // byte right after the first load, or aborts with reset after abort_hb half-bits.
  task automatic run_stream(input int n_bytes, input bit wr2, input logic [7:0] b2,
                            input int abort_hb);
    int hl, total, w, done_cnt;
    bit ok_busy, ok_oe;
    logic [0:0] e;
    hl = 2 * (int'(div) + 1) * ((hb == 0) ? 1 : int'(hb));
    total = n_bytes * 16 * hl;
    ok_busy = 1'b1;
    ok_oe = 1'b1;
    done_cnt = 0;
    w = 0;
    while (!m_busy && w < 2 * (int'(div) + 1) + 3) begin @(negedge pck0); w++; end
    check("start_busy", m_busy, 1'b1);
    check("start_latency_ok", (w <= 2 * (int'(div) + 1) + 1), 1'b1);
    if (!m_busy) return;
    for (int c = 0; c <= total; c++) begin
      if (c > 0) @(negedge pck0);
      if (m_done) done_cnt++;
      if (c < total && m_busy !== 1'b1) ok_busy = 1'b0;
      if (c < total && m_done !== 1'b0) ok_busy = 1'b0;
      if (m_oe2 !== (m_dbg & ~lf_field) || m_oe3 !== (m_dbg & ~lf_field) ||
          m_oe4 !== (m_dbg & ~lf_field) || m_oe1 !== 1'b0 || m_hi !== 1'b0 || m_lo !== 1'b0)
        ok_oe = 1'b0;
      if (c < total && (c % hl) == hl / 2) begin
        if (exp_q.size() == 0) check("queue_underrun", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("halfbit", m_dbg, e);
        end
      end
      if (wr2 && c == 1) begin
        data_in    = b2;
        data_valid = 1'b1;
        enc_push(b2, sel);
      end
      if (wr2 && c == 2) data_valid = 1'b0;
      if (wr2 && c == 3) check("ready_after_wr2", m_ready, 1'b0);
      if (abort_hb > 0 && c == abort_hb * hl + 1) begin
        reset = 1'b1;
        @(negedge pck0);
        reset = 1'b0;
        check("abort_dbg", m_dbg, 1'b0);
        check("abort_busy", m_busy, 1'b0);
        check("abort_ready", m_ready, 1'b1);
        check("abort_no_done", (done_cnt == 0) && (m_done == 1'b0), 1'b1);
        exp_q.delete();
        return;
      end
      if (wr2 && n_bytes > 1 && c == 16 * hl - 1) check("ready_before_reload", m_ready, 1'b0);
      if (wr2 && n_bytes > 1 && c == 16 * hl) check("ready_at_reload", m_ready, 1'b1);
    end
    check("end_tx_done", m_done, 1'b1);
    check("end_busy", m_busy, 1'b0);
    check("end_dbg", m_dbg, 1'b0);
    check("tx_done_count", done_cnt, 1);
    check("busy_contiguous", ok_busy, 1'b1);
    check("oe_gating", ok_oe, 1'b1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int w, per;
    // Reset state
    repeat (3) @(negedge pck0);
    check("rst_adc_clk", m_adc, 1'b1);
    check("rst_dbg", m_dbg, 1'b0);
    check("rst_oe2", m_oe2, 1'b0);
    reset = 1'b0;
    @(negedge pck0);
    check("rst_ready", m_ready, 1'b1);
    check("rst_busy", m_busy, 1'b0);
    check("rst_tx_done", m_done, 1'b0);

    // Carrier half-period is divisor+1 cycles
    w = 0;
    while (m_adc == 1'b1 && w < 20) begin @(negedge pck0); w++; end
    per = 0;
    while (m_adc == 1'b0 && per < 20) begin @(negedge pck0); per++; end
    check("adc_half_period", per, int'(div) + 1);

    // Basic byte
    push_byte(8'hA5);
    run_stream(1, 1'b0, 8'h00, 0);

    // Back-to-back, no gap between bytes
    repeat (5) @(negedge pck0);
    push_byte(8'hFF);
    run_stream(2, 1'b1, 8'h00, 0);

    // Inverted polarity
    repeat (5) @(negedge pck0);
    sel = 1'b1;
    push_byte(8'h80);
    run_stream(1, 1'b0, 8'h00, 0);
    sel = 1'b0;

    // Reader field gates the load outputs only
    repeat (5) @(negedge pck0);
    lf_field = 1'b1;
    push_byte(8'h3C);
    run_stream(1, 1'b0, 8'h00, 0);
    lf_field = 1'b0;

    // Reset mid-byte with a byte pending, then a fresh byte from its MSB
    repeat (5) @(negedge pck0);
    push_byte(8'h5A);
    run_stream(2, 1'b1, 8'hC3, 5);
    repeat (3) @(negedge pck0);
    push_byte(8'h96);
    run_stream(1, 1'b0, 8'h00, 0);

    // Fastest timing: half_bit 0 acts as 1, divisor 0
    repeat (5) @(negedge pck0);
    div = 8'd0;
    hb  = 6'd0;
    push_byte(8'h01);
    run_stream(1, 1'b0, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
